ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

PS/2 keyboard receiver on the CPU clock domain. It takes the raw `keyboard_clock`/`keyboard_data` board pins, synchronizes and deglitches them, and deframes 11-bit PS/2 device-to-host frames. Good scancodes are buffered in a small first-word-fall-through FIFO that the CPU keyboard peripheral drains through a valid/ready handshake. Parity, framing and overflow errors are reported as sticky flags.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: scancode FIFO entries; must be a power of 2, minimum 2.
- `FILTER_LEN`, 3: consecutive identical synchronized samples required to change the filtered PS/2 clock level.
- `TIMEOUT`, 500: `CLK_CPU` cycles without a filtered falling edge before an in-progress frame is aborted. This is 1 ms at 500 kHz.

Ports:
- `CLK_CPU`, in, 1: sole clock; all logic on its rising edge.
- `resetp`, in, 1: reset, synchronous, active-high.
- `keyboard_clock`, in, 1: raw PS/2 clock pin; asynchronous.
- `keyboard_data`, in, 1: raw PS/2 data pin; asynchronous.
- `scancode`, out, 8: FIFO head byte; valid only while `scancode_valid` is 1.
- `scancode_valid`, out, 1: FIFO not empty.
- `scancode_ready`, in, 1: consumer accepts the head when it is 1 and `scancode_valid` is 1.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: current occupancy, 0..FIFO_DEPTH.
- `parity_error`, out, 1: sticky; set by a bad-parity frame.
- `frame_error`, out, 1: sticky; set by a bad stop bit or a timeout.
- `overflow`, out, 1: sticky; set when a good byte is dropped because the FIFO is full.
- `err_clear`, in, 1: clears all three sticky flags.

## Operation
- **Synchronizers.** Each pin passes through a 2-flop synchronizer. Both synchronizers reset to 1.
- **Clock filter.** The filtered clock `fclk` (reset 1) takes the synchronized clock level only after FILTER_LEN consecutive equal samples that differ from the current `fclk`.
- **Falling-edge pulse.** `fall` is 1 for exactly one cycle when `fclk` goes 1→0. Data is sampled from synchronizer stage 2 in that same cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP. Reset state is IDLE.
  - IDLE: on `fall`, if data = 0, go to DATA with bit count 0. If data = 1, stay in IDLE and flag nothing.
  - DATA: on each `fall`, shift the data bit in LSB-first (shift right, new bit into bit 7). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, store the bit and go to STOP. Parity is good when the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - STOP: on `fall`, always return to IDLE.
    - Stop = 1 and parity good: push the byte.
    - Stop = 0: set `frame_error`, no push.
    - Stop = 1 and parity bad: set `parity_error`, no push.
    - Stop = 0 and parity bad: set only `frame_error`.
- **Timeout.**
  - The counter is cleared in IDLE and on every `fall`, and increments in every other state.
  - When it reaches TIMEOUT−1, the FSM goes to IDLE, the partial byte is discarded, and `frame_error` is set.
- **FIFO.** Circular buffer with wrapping read/write pointers; `fifo_count` is registered.
  - Pop occurs when `scancode_valid` and `scancode_ready` are both 1.
  - Push when full and no pop in the same cycle: byte dropped, `overflow` set, contents unchanged.
  - Push and pop in the same cycle are always both performed, including when full or when count = 1. The count is unchanged.
  - Pop when empty is ignored.
- **Sticky flags.** If `err_clear` and a flag-setting event occur in the same cycle, set wins.
- **Reset (mid-frame included).**
  - Outputs: `scancode_valid`, `fifo_count` and all flags = 0. `scancode` = 0.
  - Internal state: FIFO emptied, FSM in IDLE, shift register and counters cleared, `fclk` = 1.
  - A frame that is partially received when reset deasserts is lost. Its remaining bits are treated as noise: the FSM stays in IDLE on any `fall` that samples data = 1.

## Timing
- **Pin to `fall`.** Let k be the first `CLK_CPU` edge that captures the new pin level. `fall` is 1 in cycle k+1+FILTER_LEN.
- **Push latency.** On a good frame, `scancode_valid` rises and `fifo_count` increments on the edge after the STOP-bit `fall` cycle.
- **Pop latency.** After a pop edge, the next head appears, or `scancode_valid` falls, in the same clock edge. There are no bubbles.
- **Outputs.** All outputs are registered or derived from registers only. There is no combinational path from `scancode_ready` to any output.
- **Throughput.** One byte per frame, with frames about 30–50 `CLK_CPU` cycles per PS/2 bit. The FIFO absorbs bursts of FIFO_DEPTH bytes.

## Test plan
- **Good frame.** Drive a frame for 0x1C (start 0, data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12 kHz with `scancode_ready`=0. Expect `scancode`=0x1C, `scancode_valid`=1, `fifo_count`=1, no flags.
- **Parity error.** Send 0x1C with parity 1. Expect no push and `parity_error`=1. Then pulse `err_clear` and expect `parity_error`=0.
- **Timeout.** Send start plus 4 data bits, then hold the clock high for 600 cycles. Expect `frame_error`=1 and FSM in IDLE. A following frame for 0xF0 is received correctly.
- **Overflow.** With `scancode_ready`=0, send 9 frames 0x01..0x09. Expect `fifo_count`=8 and `overflow`=1. Then with `scancode_ready`=1, expect the drained order 0x01..0x08 on consecutive cycles, with no 0x09.
- **Glitch and simultaneous events.**
  - Inject a 1-cycle low glitch on `keyboard_clock` mid-frame: the byte is received unchanged.
  - Full FIFO with push and pop in the same cycle: count stays 8 and the new byte is appended.
  - `err_clear` coincident with a parity failure: the flag remains 1.
- **Reset mid-frame.** Assert `resetp` for 1 cycle after 5 bits of a frame, with 3 bytes queued. Expect `fifo_count`=0, `scancode_valid`=0 and all flags 0. A new complete frame 0x5A is then received.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin synchronizers, clock deglitch filter, 11-bit frame
// deframer and a first-word-fall-through scancode FIFO with sticky error flags.
module ps2_keyboard_rx #(
   parameter int FIFO_DEPTH = 8,
   parameter int FILTER_LEN = 3,
   parameter int TIMEOUT    = 500
) (
   input  logic                          CLK_CPU,
   input  logic                          resetp,
   input  logic                          keyboard_clock,
   input  logic                          keyboard_data,
   output logic [7:0]                    scancode,
   output logic                          scancode_valid,
   input  logic                          scancode_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          parity_error,
   output logic                          frame_error,
   output logic                          overflow,
   input  logic                          err_clear
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = $clog2(FILTER_LEN) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    clk_sync, data_sync;
   logic          fclk, fclk_d, fall, bit_in;
   logic [FW-1:0] filt_cnt;

   state_t        state, state_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shift_reg, shift_n;
   logic          parity_bit, parity_n;
   logic [TW-1:0] to_cnt, to_n;
   logic          push_req, set_parity, set_frame;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          full, pop, do_push, drop;

   always_ff @(posedge CLK_CPU) begin
      if (resetp) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], keyboard_clock};
         data_sync <= {data_sync[0], keyboard_data};
      end
   end

   // fclk only follows the pin after FILTER_LEN consecutive disagreeing samples
   always_ff @(posedge CLK_CPU) begin
      if (resetp) begin
         fclk     <= 1'b1;
         fclk_d   <= 1'b1;
         filt_cnt <= '0;
      end else begin
         fclk_d <= fclk;
         if (clk_sync[1] == fclk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_LAST) begin
            fclk     <= clk_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall   = fclk_d & ~fclk;
   assign bit_in = data_sync[1];

   always_ff @(posedge CLK_CPU) begin
      if (resetp) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         to_cnt     <= '0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shift_reg  <= shift_n;
         parity_bit <= parity_n;
         to_cnt     <= to_n;
      end
   end

   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      shift_n    = shift_reg;
      parity_n   = parity_bit;
      to_n       = (state == IDLE || fall) ? '0 : to_cnt + 1'b1;
      push_req   = 1'b0;
      set_parity = 1'b0;
      set_frame  = 1'b0;
      case (state)
         IDLE: begin
            if (fall && !bit_in) begin
               state_n   = DATA;
               bit_cnt_n = '0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_n   = {bit_in, shift_reg[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
               parity_n = bit_in;
               state_n  = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_n = IDLE;
               if (!bit_in)                      set_frame  = 1'b1;
               else if (^{shift_reg, parity_bit}) push_req   = 1'b1;
               else                              set_parity = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      // a stalled keyboard must not leave the deframer stuck mid-frame
      if (state != IDLE && !fall && to_cnt == TO_LAST) begin
         state_n   = IDLE;
         bit_cnt_n = '0;
         shift_n   = '0;
         to_n      = '0;
         set_frame = 1'b1;
      end
   end

   assign scancode_valid = (fifo_count != '0);
   assign full           = (fifo_count == FULL_COUNT);
   assign pop            = scancode_valid & scancode_ready;
   assign do_push        = push_req & (~full | pop);
   assign drop           = push_req & full & ~pop;
   assign scancode       = scancode_valid ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge CLK_CPU) begin
      if (do_push) mem[wr_ptr] <= shift_reg;
   end

   always_ff @(posedge CLK_CPU) begin
      if (resetp) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (pop && !do_push) fifo_count <= fifo_count - 1'b1;
      end
   end

   // a flag-setting event in the same cycle as err_clear keeps the flag set
   always_ff @(posedge CLK_CPU) begin
      if (resetp) begin
         parity_error <= 1'b0;
         frame_error  <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         parity_error <= set_parity | (parity_error & ~err_clear);
         frame_error  <= set_frame  | (frame_error  & ~err_clear);
         overflow     <= drop       | (overflow     & ~err_clear);
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed scenarios plus random frames
// compared against a queue-based reference model of the scancode FIFO and flags.
module tb_ps2_keyboard_rx;

   localparam int DEPTH = 8;
   localparam int HALF  = 20;

   logic                      clk = 1'b0;
   logic                      resetp;
   logic                      kb_clk, kb_data;
   logic [7:0]                scancode;
   logic                      scancode_valid, scancode_ready;
   logic [$clog2(DEPTH):0]    fifo_count;
   logic                      parity_error, frame_error, overflow, err_clear;

   int        compared = 0;
   int        mismatched = 0;
   logic [7:0] model_q[$];
   bit        exp_parity, exp_frame, exp_over;

   ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(3), .TIMEOUT(500)) dut (
      .CLK_CPU(clk),
      .resetp(resetp),
      .keyboard_clock(kb_clk),
      .keyboard_data(kb_data),
      .scancode(scancode),
      .scancode_valid(scancode_valid),
      .scancode_ready(scancode_ready),
      .fifo_count(fifo_count),
      .parity_error(parity_error),
      .frame_error(frame_error),
      .overflow(overflow),
      .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, ".count"},    32'(fifo_count),     32'(model_q.size()));
      checkOutput({tag, ".valid"},    32'(scancode_valid), 32'(model_q.size() != 0));
      checkOutput({tag, ".scancode"}, 32'(scancode),       (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0);
      checkOutput({tag, ".parity"},   32'(parity_error),   32'(exp_parity));
      checkOutput({tag, ".frame"},    32'(frame_error),    32'(exp_frame));
      checkOutput({tag, ".overflow"}, 32'(overflow),       32'(exp_over));
   endtask

   // Drives frame bits first..last; coinc 1 pulses ready, 2 pulses err_clear in the stop-bit push cycle
   task automatic applyStimulus(input logic [7:0] b, input bit flip_par, input bit stop_val,
                                input int first, input int last, input bit glitch, input int coinc);
      logic [10:0] bits;
      bits = {stop_val, (~^b) ^ flip_par, b, 1'b0};
      for (int i = first; i <= last; i++) begin
         @(negedge clk);
         kb_data = bits[i];
         if (glitch && i == 4) begin
            repeat (5) @(negedge clk);
            kb_clk = 1'b0;
            @(negedge clk);
            kb_clk = 1'b1;
            repeat (HALF - 6) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         kb_clk = 1'b0;
         if (coinc != 0 && i == 10) begin
            repeat (5) @(posedge clk);
            @(negedge clk);
            if (coinc == 1) scancode_ready = 1'b1;
            else            err_clear = 1'b1;
            @(negedge clk);
            scancode_ready = 1'b0;
            err_clear = 1'b0;
            repeat (HALF - 7) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         kb_clk = 1'b1;
      end
      repeat (10) @(negedge clk);
      kb_data = 1'b1;
      if (first == 0 && last == 10) begin
         if (coinc == 2) {exp_parity, exp_frame, exp_over} = 3'b000;
         if (coinc == 1 && model_q.size() != 0) void'(model_q.pop_front());
         if (!stop_val)                  exp_frame = 1'b1;
         else if (flip_par)              exp_parity = 1'b1;
         else if (model_q.size() < DEPTH) model_q.push_back(b);
         else                            exp_over = 1'b1;
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkState("drain");
         scancode_ready = 1'b1;
         @(posedge clk);
         if (model_q.size() != 0) void'(model_q.pop_front());
      end
      @(negedge clk);
      scancode_ready = 1'b0;
   endtask

   task automatic pulseClear();
      @(negedge clk);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      {exp_parity, exp_frame, exp_over} = 3'b000;
   endtask

   task automatic pulseReset();
      @(negedge clk);
      resetp = 1'b1;
      @(negedge clk);
      resetp = 1'b0;
      model_q.delete();
      {exp_parity, exp_frame, exp_over} = 3'b000;
   endtask

   initial begin
      logic [7:0] rb;
      int         kind;
      kb_clk = 1'b1;
      kb_data = 1'b1;
      scancode_ready = 1'b0;
      err_clear = 1'b0;
      resetp = 1'b1;
      repeat (4) @(negedge clk);
      resetp = 1'b0;
      model_q.delete();
      {exp_parity, exp_frame, exp_over} = 3'b000;
      @(negedge clk);
      checkState("reset");

      applyStimulus(8'h1C, 1'b0, 1'b1, 0, 10, 1'b0, 0);
      checkState("good");
      checkOutput("good.byte", 32'(scancode), 32'h1C);
      drain(2);

      applyStimulus(8'h1C, 1'b1, 1'b1, 0, 10, 1'b0, 0);
      checkState("parity");
      pulseClear();
      @(negedge clk);
      checkState("errclr");

      applyStimulus(8'hA5, 1'b0, 1'b1, 0, 4, 1'b0, 0);
      repeat (600) @(negedge clk);
      exp_frame = 1'b1;
      checkState("timeout");
      applyStimulus(8'hF0, 1'b0, 1'b1, 0, 10, 1'b0, 0);
      checkState("after_timeout");
      drain(2);
      pulseClear();

      for (int v = 1; v <= 9; v++) applyStimulus(8'(v), 1'b0, 1'b1, 0, 10, 1'b0, 0);
      checkState("overflow");
      drain(9);
      pulseClear();

      applyStimulus(8'h3C, 1'b0, 1'b1, 0, 10, 1'b1, 0);
      checkState("glitch");
      drain(2);

      for (int v = 16; v < 16 + DEPTH; v++) applyStimulus(8'(v), 1'b0, 1'b1, 0, 10, 1'b0, 0);
      applyStimulus(8'h55, 1'b0, 1'b1, 0, 10, 1'b0, 1);
      checkState("pushpop");
      drain(DEPTH + 1);

      applyStimulus(8'h66, 1'b1, 1'b1, 0, 10, 1'b0, 2);
      checkState("clear_vs_parity");
      pulseClear();

      for (int v = 0; v < 3; v++) applyStimulus(8'(8'h70 + v), 1'b0, 1'b1, 0, 10, 1'b0, 0);
      applyStimulus(8'hFF, 1'b0, 1'b1, 0, 4, 1'b0, 0);
      pulseReset();
      @(negedge clk);
      checkState("midreset");
      applyStimulus(8'hFF, 1'b0, 1'b1, 5, 10, 1'b0, 0);
      checkState("noise");
      applyStimulus(8'h5A, 1'b0, 1'b1, 0, 10, 1'b0, 0);
      checkState("after_reset");
      drain(2);

      for (int n = 0; n < 20; n++) begin
         rb   = 8'($urandom);
         kind = int'($urandom_range(0, 9));
         applyStimulus(rb, (kind == 0 || kind == 2), !(kind == 1 || kind == 2), 0, 10, 1'b0, 0);
         checkState("random");
         if ($urandom_range(0, 2) == 0) drain(int'($urandom_range(1, 4)));
         if ($urandom_range(0, 3) == 0) pulseClear();
      end
      drain(DEPTH + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
